// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared types and default timing constants for the push-button
//               conditioner.
//               rpt_state_t - auto-repeat FSM state encoding
//               DEF_*       - default cycle counts derived from CLK_HZ
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int CLK_HZ              = 27_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int DEF_HOLD_CYCLES     = CLK_HZ / 2;    // 500 ms
    localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 10;   // 100 ms

endpackage
`default_nettype wire

// File: rtl/button_if.sv
`default_nettype none
// ============================================================================
// Module      : button_if
// Description : Bundle of the per-channel button pins and conditioned outputs.
//               btn_n_i       - raw active-low pins (asynchronous)
//               btn_level_o   - debounced level, 1 = pressed
//               btn_press_o   - one-cycle press strobe
//               btn_release_o - one-cycle release strobe
//               btn_repeat_o  - one-cycle auto-repeat strobe
//               master: pad/stimulus side; slave: conditioner side.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_n_i;
    logic [NUM_BTN-1:0] btn_level_o;
    logic [NUM_BTN-1:0] btn_press_o;
    logic [NUM_BTN-1:0] btn_release_o;
    logic [NUM_BTN-1:0] btn_repeat_o;

    modport master (
        output btn_n_i,
        input  btn_level_o, btn_press_o, btn_release_o, btn_repeat_o
    );

    modport slave (
        input  btn_n_i,
        output btn_level_o, btn_press_o, btn_release_o, btn_repeat_o
    );
endinterface
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One button channel: two-flop synchroniser, debouncer and
//               auto-repeat FSM.
//               clk, rst_n    - clock, asynchronous active-low reset
//               btn_n         - raw active-low pin
//               btn_level     - debounced level (1 = pressed)
//               btn_press     - strobe one cycle after accepted press
//               btn_release   - strobe one cycle after accepted release
//               btn_repeat    - auto-repeat strobe while held
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  btn_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] RLAST = HW'(REPEAT_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          st;          // debounced state, 1 = pressed
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    rpt_state_t    state;

    logic differs;
    logic press_evt;
    logic release_evt;

    // Synchroniser resets to "released" so leaving reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign differs = (~sync2) != st;

    // dcnt never exceeds DLAST: it clears on the flip, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= 1'b0;
            dcnt <= '0;
        end else if (!differs) begin
            dcnt <= '0;
        end else if (dcnt == DLAST) begin
            st   <= ~st;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    // btn_level is the registered copy of st, so a mismatch marks the edge
    // cycle of an accepted transition.
    assign press_evt   = st & ~btn_level;
    assign release_evt = ~st & btn_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;
        end else begin
            btn_level   <= st;
            btn_press   <= press_evt;
            btn_release <= release_evt;
            btn_repeat  <= 1'b0;
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    if (REPEAT_EN && press_evt) begin
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (release_evt) begin
                        state <= IDLE;
                        hcnt  <= '0;
                    end else if (hcnt == HLAST) begin
                        btn_repeat <= 1'b1;
                        hcnt       <= '0;
                        state      <= REPEAT;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                REPEAT: begin
                    if (release_evt) begin
                        state <= IDLE;
                        hcnt  <= '0;
                    end else if (hcnt == RLAST) begin
                        btn_repeat <= 1'b1;
                        hcnt       <= '0;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    hcnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Multi-channel push-button front end; one independent
//               button_channel per bit.
//               clk, rst_n - clock, asynchronous active-low reset
//               bus        - button_if slave (raw pins in, level/strobes out)
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  wire     clk,
    input  wire     rst_n,
    button_if.slave bus
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_n       (bus.btn_n_i[i]),
            .btn_level   (bus.btn_level_o[i]),
            .btn_press   (bus.btn_press_o[i]),
            .btn_release (bus.btn_release_o[i]),
            .btn_repeat  (bus.btn_repeat_o[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with
//               DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, NUM_BTN=2.
//               dut0 has auto-repeat enabled, dut1 has it disabled.
//               Edge numbering: edge 0 is the first posedge that samples the
//               new raw pin value in each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    button_if #(.NUM_BTN(2)) bus0 ();
    button_if #(.NUM_BTN(2)) bus1 ();

    button_conditioner #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    button_conditioner #(
        .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3), .REPEAT_EN(1'b0)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {level, press, release, repeat}, 2 bits each
    logic [7:0] obs0;
    logic [7:0] obs1;
    assign obs0 = {bus0.btn_level_o, bus0.btn_press_o, bus0.btn_release_o, bus0.btn_repeat_o};
    assign obs1 = {bus1.btn_level_o, bus1.btn_press_o, bus1.btn_release_o, bus1.btn_repeat_o};

    // Holds reset for two edges with pins released, checks outputs, then
    // releases reset just after an edge so the next posedge is edge 0.
    task automatic test_reset();
        rst_n = 1'b0;
        bus0.btn_n_i = 2'b11;
        bus1.btn_n_i = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs0 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_dut0: got %b want %b", obs0, 8'h00);
        end
        n_vec++;
        if (obs1 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_dut1: got %b want %b", obs1, 8'h00);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [7:0] exp;
        test_reset();
        bus0.btn_n_i = 2'b10;
        for (int e = 0; e <= 23; e++) begin
            @(posedge clk);
            #1;
            exp = {(e >= 6) ? 2'b01 : 2'b00,
                   (e == 6) ? 2'b01 : 2'b00,
                   2'b00,
                   (e == 16 || e == 19 || e == 22) ? 2'b01 : 2'b00};
            n_vec++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL clean_press edge %0d: got %b want %b", e, obs0, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp;
        test_reset();
        bus0.btn_n_i = 2'b01;           // bit1 low for edges 0..2
        for (int e = 0; e <= 14; e++) begin
            @(posedge clk);
            #1;
            exp = {(e >= 10) ? 2'b10 : 2'b00,
                   (e == 10) ? 2'b10 : 2'b00,
                   2'b00, 2'b00};
            n_vec++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL bounce edge %0d: got %b want %b", e, obs0, exp);
            end
            bus0.btn_n_i[1] = (e + 1 == 3);   // one-cycle bounce high at edge 3
        end
    endtask

    task automatic test_release();
        logic [7:0] exp;
        test_reset();
        bus0.btn_n_i = 2'b10;
        for (int e = 0; e <= 25; e++) begin
            @(posedge clk);
            #1;
            exp = {(e >= 6 && e <= 13) ? 2'b01 : 2'b00,
                   (e == 6) ? 2'b01 : 2'b00,
                   (e == 14) ? 2'b01 : 2'b00,
                   2'b00};
            n_vec++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL release edge %0d: got %b want %b", e, obs0, exp);
            end
            bus0.btn_n_i[0] = (e + 1 >= 8);   // raw release first sampled at edge 8
        end
    endtask

    task automatic test_both();
        logic [7:0] exp;
        test_reset();
        bus0.btn_n_i = 2'b00;
        for (int e = 0; e <= 8; e++) begin
            @(posedge clk);
            #1;
            exp = {(e >= 6) ? 2'b11 : 2'b00,
                   (e == 6) ? 2'b11 : 2'b00,
                   2'b00, 2'b00};
            n_vec++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL both edge %0d: got %b want %b", e, obs0, exp);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [7:0] exp;
        test_reset();
        bus0.btn_n_i = 2'b10;
        for (int e = 0; e <= 17; e++) begin
            @(posedge clk);
            #1;
            exp = {(e >= 6) ? 2'b01 : 2'b00,
                   (e == 6) ? 2'b01 : 2'b00,
                   2'b00,
                   (e == 16) ? 2'b01 : 2'b00};
            n_vec++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL pre_reset edge %0d: got %b want %b", e, obs0, exp);
            end
        end
        // Asynchronous assertion between edges while in REPEAT.
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs0 !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: got %b want %b", obs0, 8'h00);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs0 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_held: got %b want %b", obs0, 8'h00);
        end
        rst_n = 1'b1;                   // button still held
        for (int e = 0; e <= 8; e++) begin
            @(posedge clk);
            #1;
            exp = {(e >= 6) ? 2'b01 : 2'b00,
                   (e == 6) ? 2'b01 : 2'b00,
                   2'b00, 2'b00};
            n_vec++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL post_reset edge %0d: got %b want %b", e, obs0, exp);
            end
        end
    endtask

    task automatic test_no_repeat();
        logic [7:0] exp;
        int press_cnt;
        int rpt_cnt;
        press_cnt = 0;
        rpt_cnt   = 0;
        test_reset();
        bus1.btn_n_i = 2'b10;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk);
            #1;
            press_cnt += int'(bus1.btn_press_o[0]);
            rpt_cnt   += int'(bus1.btn_repeat_o[0]);
            exp = {(e >= 6) ? 2'b01 : 2'b00,
                   (e == 6) ? 2'b01 : 2'b00,
                   2'b00, 2'b00};
            n_vec++;
            if (obs1 !== exp) begin
                n_err++;
                $display("FAIL no_repeat edge %0d: got %b want %b", e, obs1, exp);
            end
        end
        n_vec++;
        if (press_cnt !== 1) begin
            n_err++;
            $display("FAIL no_repeat_press_count: got %0d want 1", press_cnt);
        end
        n_vec++;
        if (rpt_cnt !== 0) begin
            n_err++;
            $display("FAIL no_repeat_repeat_count: got %0d want 0", rpt_cnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus0.btn_n_i = 2'b11;
        bus1.btn_n_i = 2'b11;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_both();
        test_reset_mid_repeat();
        test_no_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel front end for the board's push buttons. It synchronises each raw active-low button pin into the `clk` domain, debounces it, and produces a clean level plus single-cycle press, release and auto-repeat strobes. It sits directly upstream of the LED/counter control logic, which consumes the strobes instead of sampling pins every cycle.

## Interface
- `NUM_BTN`, default 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 270_000 (10 ms at 27 MHz): consecutive cycles a changed input must hold before it is accepted; minimum 1.
- `HOLD_CYCLES`, default 13_500_000 (500 ms): press duration before the first repeat strobe; minimum 1.
- `REPEAT_CYCLES`, default 2_700_000 (100 ms): period of subsequent repeat strobes; minimum 1.
- `REPEAT_EN`, default 1: 0 disables the repeat strobes entirely.
- `clk`, input, 1: system clock (27 MHz crystal).
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn_n_i`, input, NUM_BTN: raw button pins; 0 means pressed; asynchronous to `clk`.
- `btn_level_o`, output, NUM_BTN: debounced state; 1 means pressed.
- `btn_press_o`, output, NUM_BTN: one-cycle strobe on each accepted press.
- `btn_release_o`, output, NUM_BTN: one-cycle strobe on each accepted release.
- `btn_repeat_o`, output, NUM_BTN: one-cycle strobe for each auto-repeat while the button is held.

## Operation
- Channels are fully independent; every rule below applies per bit.
- **Synchroniser:** two flops. Reset value is 1 (released), so reset never produces a spurious press.
- **Debouncer:**
  - Holds a stable state `st` (reset: released) and a counter `dcnt` (reset: 0).
  - When the synchronised input equals `st`, `dcnt` is cleared to 0.
  - When it differs, `dcnt` increments.
  - On the cycle `dcnt` reaches DEBOUNCE_CYCLES-1 while the input still differs, `st` flips and `dcnt` clears.
  - Any bounce back to `st` before that cycle restarts the count from 0.
- **Strobe logic:**
  - `btn_press_o` pulses for the one cycle after `st` goes released→pressed.
  - `btn_release_o` pulses for the one cycle after `st` goes pressed→released.
  - All outputs are registered.
- **Repeat FSM** (states IDLE, HELD, REPEAT; hold counter `hcnt`):
  - IDLE: on accepted press, go to HELD with `hcnt`=0.
  - HELD: `hcnt` increments. When it reaches HOLD_CYCLES-1, pulse `btn_repeat_o`, clear `hcnt`, go to REPEAT.
  - REPEAT: `hcnt` increments. Each time it reaches REPEAT_CYCLES-1, pulse `btn_repeat_o` and clear `hcnt`.
  - Accepted release from HELD or REPEAT: go to IDLE, clear `hcnt`, no repeat strobe that cycle.
  - REPEAT_EN=0: the FSM never leaves IDLE and `btn_repeat_o` stays 0.
- **Mutual exclusion:** press and repeat never coincide; repeat and release never coincide.
- **Counter widths:** `$clog2(param+1)`. Counters must never wrap; a saturated count is impossible by construction.

## Timing
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset may assert mid-press or mid-repeat; the channel returns to released with no strobe.
- After `rst_n` deasserts with a button held, the press is accepted after the normal debounce latency.
- Press latency: a raw edge first sampled at edge k gives `btn_level_o` = 1 and `btn_press_o` = 1 after edge k+DEBOUNCE_CYCLES+2 (two synchroniser edges plus DEBOUNCE_CYCLES). Release has the same latency.
- First repeat strobe: HOLD_CYCLES cycles after the press strobe. Later strobes: every REPEAT_CYCLES cycles.
- A release accepted on the same edge that a repeat would fire suppresses that repeat.

## Structure
- Package `button_pkg`:
  - `rpt_state_t` enum (IDLE, HELD, REPEAT).
  - Default timing constants derived from `CLK_HZ` = 27_000_000.
- Sub-module `button_channel` (synchroniser, debouncer, FSM for one bit).
- Top level `button_conditioner` instantiates `button_channel` NUM_BTN times in a generate loop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, NUM_BTN=2.
1. Clean press of `btn_n_i[0]` at edge 0, held: level and press strobe at edge 6; repeat strobes at edges 16, 19, 22.
2. Bounce of `btn_n_i[1]` (low 3 cycles, high 1, low steady from edge 4): press strobe exactly once, at edge 10.
3. Press, then release after 8 accepted cycles: no repeat strobe; release strobe 6 edges after the raw release.
4. Both buttons pressed on the same edge: identical independent strobes on bits 0 and 1 at edge 6.
5. `rst_n` asserted during REPEAT: all outputs 0 immediately. Button still held at deassert: fresh press strobe 6 edges later.
6. REPEAT_EN=0 with a button held for 50 cycles: exactly one press strobe, zero repeat strobes.
